// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle for the branch resolve unit: operands, op class, prediction and result.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  A;
  logic [XLEN-1:0]  B;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             Branch;
  logic             Jal;
  logic             Jalr;
  logic [2:0]       funct3;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             out_valid;
  logic             out_ready;
  logic             br_taken;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  redirect_pc;
  logic             mispredict;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output flush, in_valid, A, B, pc, imm, Branch, Jal, Jalr, funct3,
           pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, br_taken, target, redirect_pc, mispredict,
           illegal, br_count, mp_count
  );

  modport slave (
    input  flush, in_valid, A, B, pc, imm, Branch, Jal, Jalr, funct3,
           pred_taken, pred_target, out_ready,
    output in_ready, out_valid, br_taken, target, redirect_pc, mispredict,
           illegal, br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver with mispredict detection, optional one-entry
// output register (PIPE) behind valid/ready, flush, and saturating perf counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int PIPE  = 1,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  localparam logic [XLEN-1:0]  FOUR    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic            is_jalr, is_jal, is_br, ctl, cond, rsv;
  logic            taken, ill, mp;
  logic [XLEN-1:0] jalr_sum, tgt, fall, redir;
  logic            out_ctl, cnt_en;

  always_comb begin
    is_jalr  = bus.Jalr;
    is_jal   = bus.Jal && !bus.Jalr;
    is_br    = bus.Branch && !bus.Jal && !bus.Jalr;
    ctl      = is_jalr || is_jal || is_br;
    cond     = 1'b0;
    rsv      = 1'b0;
    case (bus.funct3)
      3'b000:  cond = (bus.A == bus.B);
      3'b001:  cond = (bus.A != bus.B);
      3'b100:  cond = ($signed(bus.A) <  $signed(bus.B));
      3'b101:  cond = ($signed(bus.A) >= $signed(bus.B));
      3'b110:  cond = (bus.A <  bus.B);
      3'b111:  cond = (bus.A >= bus.B);
      default: rsv  = 1'b1;
    endcase
    ill      = is_br && rsv;
    taken    = is_jalr || is_jal || (is_br && cond);
    jalr_sum = bus.A + bus.imm;
    tgt      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.pc + bus.imm);
    fall     = bus.pc + FOUR;
    redir    = taken ? tgt : fall;
    // Illegal ops always resolve not-taken, so the generic rule reduces to pred_taken.
    if (ctl)
      mp = (taken != bus.pred_taken) || (taken && (tgt != bus.pred_target));
    else
      mp = 1'b0;
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic            r_valid, r_taken, r_mp, r_ill, r_ctl;
      logic [XLEN-1:0] r_tgt, r_redir;
      logic            accept;

      assign bus.in_ready = !r_valid || bus.out_ready;
      assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_taken <= 1'b0;
          r_mp    <= 1'b0;
          r_ill   <= 1'b0;
          r_ctl   <= 1'b0;
          r_tgt   <= '0;
          r_redir <= '0;
        end else if (bus.flush) begin
          r_valid <= 1'b0;
        end else if (accept) begin
          r_valid <= 1'b1;
          r_taken <= taken;
          r_mp    <= mp;
          r_ill   <= ill;
          r_ctl   <= ctl;
          r_tgt   <= tgt;
          r_redir <= redir;
        end else if (bus.out_ready) begin
          r_valid <= 1'b0;
        end
      end

      assign bus.out_valid   = r_valid;
      assign bus.br_taken    = r_taken;
      assign bus.target      = r_tgt;
      assign bus.redirect_pc = r_redir;
      assign bus.mispredict  = r_mp;
      assign bus.illegal     = r_ill;
      assign out_ctl         = r_ctl;
    end else begin : g_comb
      assign bus.in_ready    = bus.out_ready;
      assign bus.out_valid   = bus.in_valid && !bus.flush;
      assign bus.br_taken    = taken;
      assign bus.target      = tgt;
      assign bus.redirect_pc = redir;
      assign bus.mispredict  = mp;
      assign bus.illegal     = ill;
      assign out_ctl         = ctl;
    end
  endgenerate

  assign cnt_en = bus.out_valid && bus.out_ready && !bus.flush && out_ctl;

  logic [CNT_W-1:0] br_cnt, mp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (cnt_en) begin
      if (br_cnt != '1)
        br_cnt <= br_cnt + CNT_ONE;
      if (bus.mispredict && (mp_cnt != '1))
        mp_cnt <= mp_cnt + CNT_ONE;
    end
  end

  assign bus.br_count = br_cnt;
  assign bus.mp_count = mp_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: registered (PIPE=1) and pass-through (PIPE=0) instances
// fed identical stimulus, results scored against a queue of model predictions.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(4)) bus  ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(4)) cbus ();

  branch_resolve_unit #(.XLEN(32), .PIPE(1), .CNT_W(4)) u_pipe (.clk(clk), .rst(rst), .bus(bus));
  branch_resolve_unit #(.XLEN(32), .PIPE(0), .CNT_W(4)) u_comb (.clk(clk), .rst(rst), .bus(cbus));

  assign cbus.flush       = bus.flush;
  assign cbus.in_valid    = bus.in_valid;
  assign cbus.A           = bus.A;
  assign cbus.B           = bus.B;
  assign cbus.pc          = bus.pc;
  assign cbus.imm         = bus.imm;
  assign cbus.Branch      = bus.Branch;
  assign cbus.Jal         = bus.Jal;
  assign cbus.Jalr        = bus.Jalr;
  assign cbus.funct3      = bus.funct3;
  assign cbus.pred_taken  = bus.pred_taken;
  assign cbus.pred_target = bus.pred_target;
  assign cbus.out_ready   = bus.out_ready;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect;
    logic        mp;
    logic        ill;
    logic        ctl;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   n_pop  = 0;
  exp_t q[$];
  logic [3:0] m_br, m_mp, c_br, c_mp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                                 input logic [31:0] im, input bit pt, input logic [31:0] pg);
    exp_t e;
    e.taken = 1'b0; e.target = p + im; e.mp = 1'b0; e.ill = 1'b0;
    e.ctl = br || jal || jalr;
    if (jalr) begin
      e.taken  = 1'b1;
      e.target = (a + im) & 32'hFFFF_FFFE;
    end else if (jal) begin
      e.taken = 1'b1;
    end else if (br) begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = ($signed(a) < $signed(b));
        3'd5: e.taken = !($signed(a) < $signed(b));
        3'd6: e.taken = (a < b);
        3'd7: e.taken = !(a < b);
        default: e.ill = 1'b1;
      endcase
    end
    e.redirect = e.taken ? e.target : p + 32'd4;
    if (e.ill)      e.mp = pt;
    else if (e.ctl) e.mp = (e.taken != pt) || (e.taken && e.target != pg);
    return e;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic exp_t cur_model();
    return model(bus.Branch, bus.Jal, bus.Jalr, bus.funct3, bus.A, bus.B, bus.pc, bus.imm,
                 bus.pred_taken, bus.pred_target);
  endfunction

  task automatic cmp_res(input string pfx, input exp_t e, input logic tk, input logic [31:0] tg,
                         input logic [31:0] rd, input logic m, input logic il);
    chk({pfx, "_taken"}, tk, e.taken);
    chk({pfx, "_redirect"}, rd, e.redirect);
    chk({pfx, "_mispredict"}, m, e.mp);
    chk({pfx, "_illegal"}, il, e.ill);
    if (e.ctl) chk({pfx, "_target"}, tg, e.target);
  endtask

  // Scoreboard: check at the falling edge, account for the handshakes of the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_br = '0; m_mp = '0; c_br = '0; c_mp = '0;
    end else begin
      chk("pipe_out_valid", bus.out_valid, q.size() != 0);
      chk("pipe_br_count", bus.br_count, m_br);
      chk("pipe_mp_count", bus.mp_count, m_mp);
      if (bus.out_valid && bus.flush) begin
        if (q.size() != 0) void'(q.pop_front());
      end else if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        e = q.pop_front();
        n_pop++;
        cmp_res("pipe", e, bus.br_taken, bus.target, bus.redirect_pc, bus.mispredict, bus.illegal);
        if (e.ctl) begin
          m_br = sat_inc(m_br);
          if (e.mp) m_mp = sat_inc(m_mp);
        end
      end
      if (bus.in_valid && bus.in_ready && !bus.flush) q.push_back(cur_model());

      chk("comb_out_valid", cbus.out_valid, bus.in_valid && !bus.flush);
      chk("comb_in_ready", cbus.in_ready, bus.out_ready);
      chk("comb_br_count", cbus.br_count, c_br);
      chk("comb_mp_count", cbus.mp_count, c_mp);
      if (bus.in_valid && !bus.flush) begin
        e = cur_model();
        cmp_res("comb", e, cbus.br_taken, cbus.target, cbus.redirect_pc, cbus.mispredict, cbus.illegal);
        if (bus.out_ready && e.ctl) begin
          c_br = sat_inc(c_br);
          if (e.mp) c_mp = sat_inc(c_mp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                    input logic [31:0] im, input bit pt, input logic [31:0] pg);
    bus.in_valid = 1'b1;
    bus.Branch = br; bus.Jal = jal; bus.Jalr = jalr; bus.funct3 = f3;
    bus.A = a; bus.B = b; bus.pc = p; bus.imm = im;
    bus.pred_taken = pt; bus.pred_target = pg;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.Branch = 1'b0; bus.Jal = 1'b0; bus.Jalr = 1'b0;
  endtask

  initial begin
    logic [31:0] saved_tgt, p, im;
    logic [3:0]  saved_br, saved_mp;
    int          pops0, r;

    rst = 1'b1;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    op(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_br_count", bus.br_count, 4'd0);
    chk("rst_mp_count", bus.mp_count, 4'd0);

    // signed less-than, taken, mispredicted
    op(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0, 0);
    cyc(); idle();
    chk("blt_valid", bus.out_valid, 1'b1);
    chk("blt_taken", bus.br_taken, 1'b1);
    chk("blt_target", bus.target, 32'h120);
    chk("blt_redirect", bus.redirect_pc, 32'h120);
    chk("blt_mispredict", bus.mispredict, 1'b1);
    cyc();
    chk("blt_br_count", bus.br_count, 4'd1);
    chk("blt_mp_count", bus.mp_count, 4'd1);

    // unsigned less-than, not taken, correctly predicted
    op(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0, 32'h120);
    cyc(); idle();
    chk("bltu_taken", bus.br_taken, 1'b0);
    chk("bltu_redirect", bus.redirect_pc, 32'h104);
    chk("bltu_mispredict", bus.mispredict, 1'b0);

    // jalr bit-0 clearing, back to back
    op(0, 0, 1, 3'd0, 32'h1001, 32'd0, 32'h200, 32'h4, 1, 32'h1004);
    cyc();
    chk("jalr0_target", bus.target, 32'h1004);
    chk("jalr0_mispredict", bus.mispredict, 1'b0);
    op(0, 0, 1, 3'd0, 32'h1003, 32'd0, 32'h200, 32'h4, 1, 32'h1004);
    cyc(); idle();
    chk("jalr1_target", bus.target, 32'h1006);
    chk("jalr1_mispredict", bus.mispredict, 1'b1);
    cyc();

    // backpressure with a held request, then a full-rate stream
    pops0 = n_pop;
    bus.out_ready = 1'b0;
    op(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h200, 32'hFFFF_FFF8, 1, 32'h1F8);
    cyc();
    op(0, 1, 0, 3'b010, 32'd0, 32'd0, 32'h300, 32'h40, 1, 32'h340);
    saved_tgt = bus.target;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_target_stable", bus.target, saved_tgt);
      cyc();
    end
    bus.out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      r  = $urandom_range(0, 3);
      p  = 32'h4000 + 32'(i * 16);
      im = 32'($urandom_range(0, 255)) - 32'd128;
      op(r == 1, r == 2, r == 3, 3'($urandom_range(0, 7)), $urandom, $urandom, p, im,
         1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? p + im : $urandom);
      chk("stream_in_ready", bus.in_ready, 1'b1);
      cyc();
    end
    idle();
    repeat (2) cyc();
    chk("stream_pop_count", 32'(n_pop - pops0), 32'd12);
    chk("stream_queue_empty", 32'(q.size()), 32'd0);

    // flush drops both the registered and the presented op
    op(1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 0, 0);
    cyc();
    chk("flush_pre_valid", bus.out_valid, 1'b1);
    saved_br = bus.br_count; saved_mp = bus.mp_count;
    op(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h600, 32'h8, 0, 0);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0; idle();
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_br_count", bus.br_count, saved_br);
    chk("flush_mp_count", bus.mp_count, saved_mp);
    cyc();
    chk("flush_no_accept", bus.out_valid, 1'b0);

    // reserved condition code
    op(1, 0, 0, 3'b010, 32'd7, 32'd7, 32'h400, 32'h40, 1, 32'h440);
    cyc(); idle();
    chk("ill_illegal", bus.illegal, 1'b1);
    chk("ill_taken", bus.br_taken, 1'b0);
    chk("ill_mispredict", bus.mispredict, 1'b1);
    chk("ill_redirect", bus.redirect_pc, 32'h404);
    cyc();

    // counter saturation
    for (int i = 0; i < 17; i++) begin
      op(1, 0, 0, 3'b000, 32'd1, 32'd2, 32'h800 + 32'(i * 4), 32'h10, 1, 32'h0);
      cyc();
    end
    idle();
    cyc();
    chk("sat_br_count", bus.br_count, 4'hF);
    chk("sat_mp_count", bus.mp_count, 4'hF);
    chk("sat_comb_br_count", cbus.br_count, 4'hF);

    // reset mid-stream
    op(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h900, 32'h4, 0, 0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; idle();
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_br_count", bus.br_count, 4'd0);
    chk("mid_rst_mp_count", bus.mp_count, 4'd0);
    chk("mid_rst_comb_br_count", cbus.br_count, 4'd0);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch comparator, used in the pipelined core's execute stage. Resolves conditional branches and jumps: condition, target, fall-through address, and a mispredict flag against the front-end prediction. Output is registered behind a valid/ready handshake and supports flush. Saturating branch and mispredict counters feed the performance CSRs.

Parameters:
XLEN, 32, operand/PC width (32 or 64)
PIPE, 1, 1 = registered one-entry output stage; 0 = combinational pass-through
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  drop the in-flight and the presented op
in_valid  in  1  operation presented
in_ready  out  1  unit can accept
A  in  XLEN  rs1 value
B  in  XLEN  rs2 value
pc  in  XLEN  instruction PC
imm  in  XLEN  sign-extended immediate
Branch  in  1  conditional branch
Jal  in  1  jal
Jalr  in  1  jalr
funct3  in  3  branch condition select
pred_taken  in  1  front-end taken prediction
pred_target  in  XLEN  front-end predicted target
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
br_taken  out  1  resolved taken
target  out  XLEN  resolved target address
redirect_pc  out  XLEN  next PC: target if taken, else pc+4
mispredict  out  1  prediction wrong, redirect required
illegal  out  1  Branch with reserved funct3 (010/011)
br_count  out  CNT_W  resolved branches/jumps
mp_count  out  CNT_W  resolved mispredicts

Behaviour:
- Conditions, Branch=1: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010/011: not taken, illegal=1.
- Jal or Jalr: taken=1 regardless of funct3. Operation class priority is Jalr > Jal > Branch.
- No Branch, Jal or Jalr: taken=0, mispredict=0. The op is not counted, but it still passes the handshake.
- Targets wrap modulo 2^XLEN:
  - Branch and Jal: target = pc + imm.
  - Jalr: target = (A + imm) with bit 0 cleared.
  - Fall-through = pc + 4.
- mispredict = (taken != pred_taken) OR (taken AND target != pred_target). Not-taken with pred_taken=0 is never a mispredict, whatever pred_target holds.
- illegal ops: mispredict = pred_taken (redirect to fall-through).
- PIPE=1:
  - Single output register. in_ready = !out_valid OR out_ready.
  - Accept on in_valid && in_ready: register loads the result, out_valid=1 next cycle. Latency is 1 cycle.
  - Accept and drain in the same cycle is allowed, giving full throughput.
  - Outputs stay stable while out_valid && !out_ready.
- PIPE=0:
  - All result outputs are combinational from the inputs.
  - out_valid = in_valid && !flush; in_ready = out_ready.
- flush:
  - Same cycle: no accept, and no counter update for any handshake that cycle.
  - PIPE=1: out_valid=0 next cycle.
  - Flush overrides a simultaneous in_valid.
- Counters update on an output handshake (out_valid && out_ready && !flush) for Branch/Jal/Jalr ops only.
  - br_count +1 per such op. mp_count +1 additionally if mispredict.
  - Both saturate at all-ones and never wrap.
- Reset (any cycle, mid-operation included): out_valid=0, counters=0, all registered result outputs=0. in_ready=1 the cycle after reset deasserts.
- Result outputs are don't-care while out_valid=0. The bench checks them only when valid.

Test Plan:
- Branch=1, funct3=100, A=0xFFFFFFFF, B=1, pc=0x100, imm=0x20, pred_taken=0 -> br_taken=1, target=0x120, mispredict=1 one cycle after accept; br_count=1, mp_count=1.
- funct3=110 with same A/B -> br_taken=0, redirect_pc=0x104; with pred_taken=0 -> mispredict=0.
- Jalr, A=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> target=0x1004, mispredict=0; A=0x1003 -> target=0x1006, mispredict=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, outputs stable; then out_ready=1 -> consumer sees one result per cycle, no loss or duplication across a 10-op stream.
- flush asserted with out_valid=1 and a new in_valid -> out_valid=0 next cycle, counters unchanged; Branch with funct3=010 -> illegal=1, br_taken=0.
- CNT_W=4: 17 handshaked branches -> br_count holds 0xF; rst mid-stream -> counters=0 and out_valid=0 next cycle.
